// File: rtl/hp_controller.sv
// hp_controller: battle-phase player health manager.
// Once per frame it requests a bullet-damage scan and waits for the result.
// It then applies the damage/heal result to the saturating HP register,
// tracks death, and flags scans that never complete.
// Optional feature macro: HP_INVULN_EN adds a post-hit damage-immunity window
// that lasts INVULN_FRAMES frames.
module hp_controller #(
   parameter int MAX_HP        = 100,
   parameter int HEAL_AMOUNT   = 5,
   parameter int TIMEOUT       = 15,
   parameter int INVULN_FRAMES = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frameTick,
   input  logic       restart,
   input  logic       isComplete,
   input  logic [7:0] damage,
   input  logic       heal,
   output logic       start,
   output logic [7:0] hp,
   output logic       isDead,
   output logic       invuln,
   output logic       timeoutErr
);

   typedef enum logic [2:0] {IDLE, START, WAIT, APPLY, DEAD} state_t;

   localparam logic [7:0]        MaxHp8   = 8'(MAX_HP);
   localparam logic signed [9:0] MaxHp10  = 10'(MAX_HP);
   localparam logic [9:0]        Heal10   = 10'(HEAL_AMOUNT);
   localparam logic [7:0]        ToLast   = 8'(TIMEOUT - 1);

   state_t            state;
   state_t            nextState;
   logic [7:0]        toCnt;
   logic [7:0]        dmgLatch;
   logic              healLatch;
   logic [7:0]        effDamage;
   logic signed [9:0] net;
   logic [7:0]        newHp;

`ifdef HP_INVULN_EN
   logic [7:0] invCnt;

   // Immunity countdown: a landed hit arms it, each frame tick drains it.
   // Once armed, further hits are blocked (effective damage 0), so they can
   // never reload or extend the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         invCnt <= 8'd0;
      end else if (state == DEAD && restart) begin
         invCnt <= 8'd0;
      end else if (state == APPLY && effDamage != 8'd0) begin
         invCnt <= 8'(INVULN_FRAMES);
      end else if (frameTick && invCnt != 8'd0) begin
         invCnt <= invCnt - 8'd1;
      end
   end

   assign invuln    = (invCnt != 8'd0);
   assign effDamage = invuln ? 8'd0 : dmgLatch;
`else
   // Immunity window compiled out: the flag stays low and all damage lands.
   assign invuln    = (INVULN_FRAMES < 0);
   assign effDamage = dmgLatch;
`endif

   // Net HP change in 10-bit signed arithmetic, clamped to [0, MAX_HP].
   always_comb begin
      net   = $signed({2'b00, hp}) + $signed(healLatch ? Heal10 : 10'd0)
              - $signed({2'b00, effDamage});
      newHp = net[7:0];
      if (net < 10'sd0) begin
         newHp = 8'd0;
      end else if (net > MaxHp10) begin
         newHp = MaxHp8;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Frame sequencing: request a scan, wait for it (bounded), apply, or sit dead.
   always_comb begin
      nextState = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (frameTick) nextState = START;
         end
         START: begin
            start     = 1'b1;
            nextState = WAIT;
         end
         WAIT: begin
            if (isComplete)           nextState = APPLY;
            else if (toCnt == ToLast) nextState = IDLE;
         end
         APPLY: begin
            nextState = (newHp == 8'd0) ? DEAD : IDLE;
         end
         DEAD: begin
            if (restart) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // HP register, scan result latches, timeout counter and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         hp         <= MaxHp8;
         toCnt      <= 8'd0;
         dmgLatch   <= 8'd0;
         healLatch  <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         case (state)
            START: begin
               toCnt <= 8'd0;
            end
            WAIT: begin
               if (isComplete) begin
                  dmgLatch  <= damage;
                  healLatch <= heal;
               end else begin
                  toCnt <= toCnt + 8'd1;
                  if (toCnt == ToLast) timeoutErr <= 1'b1;
               end
            end
            APPLY: begin
               hp <= newHp;
            end
            DEAD: begin
               if (restart) begin
                  hp         <= MaxHp8;
                  toCnt      <= 8'd0;
                  dmgLatch   <= 8'd0;
                  healLatch  <= 1'b0;
                  timeoutErr <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign isDead = (state == DEAD);

endmodule

// File: tb/tb_hp_controller.sv
// Testbench for hp_controller: directed frames from the test plan followed by
// randomized frames, checked against a frame-level model of player health.
module tb_hp_controller;

   localparam int MaxHp   = 100;
   localparam int HealAmt = 5;
   localparam int InvFr   = 30;

   logic       clk = 1'b0;
   logic       reset, frameTick, restart, isComplete, heal;
   logic [7:0] damage;
   logic       start, isDead, invuln, timeoutErr;
   logic [7:0] hp;

   int compared   = 0;
   int mismatched = 0;

   // Frame-level model of the player.
   int modelHp;
   bit modelDead;
   bit modelErr;
   int modelInv;

   hp_controller #(.MAX_HP(MaxHp), .HEAL_AMOUNT(HealAmt), .TIMEOUT(15),
                   .INVULN_FRAMES(InvFr)) dut (
      .clk(clk), .reset(reset), .frameTick(frameTick), .restart(restart),
      .isComplete(isComplete), .damage(damage), .heal(heal), .start(start),
      .hp(hp), .isDead(isDead), .invuln(invuln), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".hp"}, 32'(hp), 32'(modelHp));
      checkOutput({tag, ".isDead"}, 32'(isDead), 32'(modelDead));
      checkOutput({tag, ".invuln"}, 32'(invuln), 32'(modelInv > 0));
      checkOutput({tag, ".timeoutErr"}, 32'(timeoutErr), 32'(modelErr));
   endtask

   task automatic modelReset();
      modelHp   = MaxHp;
      modelDead = 1'b0;
      modelErr  = 1'b0;
      modelInv  = 0;
   endtask

   task automatic modelTick();
`ifdef HP_INVULN_EN
      if (modelInv > 0) modelInv--;
`endif
   endtask

   task automatic modelApply(input int dmg, input bit hl);
      int eff;
      int n;
      eff = (modelInv > 0) ? 0 : dmg;
      n   = modelHp + (hl ? HealAmt : 0) - eff;
      if (n < 0) n = 0;
      if (n > MaxHp) n = MaxHp;
      modelHp = n;
`ifdef HP_INVULN_EN
      if (eff > 0) modelInv = InvFr;
`endif
      if (modelHp == 0) modelDead = 1'b1;
   endtask

   // One frame from IDLE: tick, scan request, then either a scanner reply after
   // lat WAIT cycles or silence until the timeout fires.
   task automatic applyStimulus(input int lat, input int dmg, input bit hl, input bit respond);
      bit dropTick;
      frameTick = 1'b1;
      step();
      modelTick();
      frameTick = 1'b0;
      checkOutput("start_pulse", 32'(start), 32'd1);
      step();
      checkOutput("start_single", 32'(start), 32'd0);
      if (respond) begin
         for (int i = 0; i < lat; i++) begin
            dropTick  = ($urandom_range(0, 4) == 0);
            frameTick = dropTick;
            step();
            if (dropTick) modelTick();
            frameTick = 1'b0;
            checkOutput("start_in_wait", 32'(start), 32'd0);
         end
         isComplete = 1'b1;
         damage     = 8'(dmg);
         heal       = hl;
         step();
         isComplete = 1'b0;
         damage     = 8'($urandom);
         heal       = 1'($urandom);
         modelApply(dmg, hl);
         step();
         checkAll("apply");
      end else begin
         for (int i = 0; i < 14; i++) step();
         checkOutput("timeout_early", 32'(timeoutErr), 32'(modelErr));
         step();
         modelErr = 1'b1;
         checkAll("timeout");
         checkOutput("timeout_nostart", 32'(start), 32'd0);
      end
   endtask

   // While dead: ticks and stray completions do nothing, then restart.
   task automatic deadAndRestart();
      frameTick  = 1'b1;
      isComplete = 1'b1;
      damage     = 8'd40;
      step();
      modelTick();
      frameTick  = 1'b0;
      isComplete = 1'b0;
      checkOutput("dead_nostart0", 32'(start), 32'd0);
      step();
      checkOutput("dead_nostart1", 32'(start), 32'd0);
      checkAll("dead");
      restart = 1'b1;
      step();
      restart = 1'b0;
      modelReset();
      checkAll("restart");
   endtask

   initial begin
      reset = 1'b1; frameTick = 1'b0; restart = 1'b0;
      isComplete = 1'b0; damage = 8'd0; heal = 1'b0;
      modelReset();
      step();
      step();
      checkAll("reset");
      checkOutput("reset.start", 32'(start), 32'd0);
      reset = 1'b0;

      // Restart outside DEAD must be ignored.
      restart = 1'b1;
      step();
      restart = 1'b0;
      checkAll("restart_idle");

      // Single hit with a 3-index scanner latency.
      applyStimulus(2, 10, 1'b0, 1'b1);
      checkOutput("single_hit_literal", 32'(hp), 32'd90);

      // Heal saturation and combined damage/heal.
      applyStimulus(1, 0, 1'b1, 1'b1);
      applyStimulus(0, 2, 1'b0, 1'b1);
      applyStimulus(3, 0, 1'b1, 1'b1);
      applyStimulus(14, 50, 1'b0, 1'b1);
      applyStimulus(5, 20, 1'b1, 1'b1);

      // Timeout, then a normal frame still starts a scan.
      applyStimulus(0, 0, 1'b0, 1'b0);
      applyStimulus(2, 0, 1'b0, 1'b1);

      // Invulnerability sequence; the model covers both builds.
      applyStimulus(2, 10, 1'b0, 1'b1);
      applyStimulus(2, 10, 1'b0, 1'b1);
      for (int i = 0; i < 29; i++) applyStimulus(0, 0, 1'b0, 1'b1);
      applyStimulus(2, 10, 1'b0, 1'b1);

      // Death and restart.
      applyStimulus(1, 255, 1'b1, 1'b1);
      if (modelDead) deadAndRestart();

      // Reset mid-scan discards the in-flight result.
      frameTick = 1'b1;
      step();
      frameTick = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      modelReset();
      isComplete = 1'b1;
      damage     = 8'd50;
      step();
      isComplete = 1'b0;
      step();
      step();
      checkAll("reset_midscan");
      checkOutput("reset_midscan.start", 32'(start), 32'd0);
      applyStimulus(2, 0, 1'b0, 1'b1);

      // Randomized frames.
      for (int n = 0; n < 60; n++) begin
         if (modelDead) begin
            deadAndRestart();
         end else if ($urandom_range(0, 9) == 0) begin
            applyStimulus(0, 0, 1'b0, 1'b0);
         end else begin
            applyStimulus($urandom_range(0, 14),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30),
                          1'($urandom_range(0, 1)), 1'b1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hp_controller.md
# hp_controller

Battle-phase player health manager. Each frame it issues a one-cycle `start` pulse to the bullet damage scanner and waits for its `isComplete` strobe. It then samples the scanner's `damage` and `heal` results and applies them to the player HP register with saturation. It also tracks death and drives a post-hit invulnerability window, and is the initiator/consumer end of the scanner's start/complete handshake.

## Interface
Parameters:
- `MAX_HP`, 100: HP at reset/restart and saturation ceiling (1..255).
- `HEAL_AMOUNT`, 5: HP added when `heal` is sampled high.
- `TIMEOUT`, 15: max cycles in WAIT before abandoning the scan.
- `INVULN_FRAMES`, 30: frames of damage immunity after a hit (only with `HP_INVULN_EN`).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frameTick`  in  1  one-cycle pulse per video frame.
- `restart`  in  1  one-cycle pulse; leaves DEAD.
- `isComplete`  in  1  scanner done strobe.
- `damage`  in  8  scanner accumulated damage, valid with `isComplete`.
- `heal`  in  1  scanner heal flag, valid with `isComplete`.
- `start`  out  1  one-cycle scan request to scanner.
- `hp`  out  8  current HP.
- `isDead`  out  1  high while in DEAD.
- `invuln`  out  1  high while the immunity window is active.
- `timeoutErr`  out  1  sticky; set on WAIT timeout, cleared by reset/restart.

## Operation
- States: IDLE, START, WAIT, APPLY, DEAD.
- Reset values: state IDLE, `hp`=MAX_HP, `start`=0, `isDead`=0, `invuln`=0, `timeoutErr`=0, timeout counter 0, invuln counter 0, latches 0.
- IDLE: `frameTick` -> START.
- START: `start`=1 for exactly this cycle -> WAIT, timeout counter cleared.
- WAIT: on `isComplete`=1, latch `damage` and `heal` -> APPLY. Otherwise increment counter; when it reaches TIMEOUT, set `timeoutErr` and go -> IDLE with no HP change.
- APPLY: compute net in 10-bit signed arithmetic: hp + (heal ? HEAL_AMOUNT : 0) - (effective damage). Clamp to [0, MAX_HP] and write `hp`. If the result is 0 -> DEAD, else -> IDLE.
- Effective damage is the latched damage, or 0 while `invuln`=1. Heal always applies, including during invulnerability. Damage and heal in the same scan net together; there is no ordering.
- DEAD: `isDead`=1; `frameTick` and `isComplete` are ignored. `restart` -> IDLE with `hp`=MAX_HP, counters cleared, `timeoutErr` cleared.
- `frameTick` in START/WAIT/APPLY is dropped, with no queuing. It still decrements the invuln counter.
- `restart` outside DEAD is ignored.
- `isComplete` outside WAIT is ignored.
- Reset in any state immediately restores all reset values. An in-flight scan result is discarded.

## Timing
- `frameTick` high at cycle t in IDLE -> `start` high at t+1 only.
- `isComplete` sampled at cycle c in WAIT -> APPLY at c+1 -> new `hp` and `isDead` visible at c+2.
- End-to-end frame latency against a 3-index scanner: `frameTick` to `hp` update is 6 cycles.
- Timeout: with no `isComplete`, `timeoutErr` rises TIMEOUT cycles after WAIT entry, and the state returns to IDLE on the same edge.
- `start` is never high on two consecutive cycles.

## Configuration
- `HP_INVULN_EN` defined:
  - APPLY with nonzero effective damage loads the invuln counter with INVULN_FRAMES and sets `invuln`.
  - Each `frameTick` decrements the counter while it is nonzero; `invuln` clears when it reaches 0.
  - A hit during the window neither reloads nor extends it.
- `HP_INVULN_EN` undefined: counter logic is absent, `invuln` is tied to 0, and every sampled damage applies.

## Test plan
- Single hit: reset, `frameTick`, scanner returns `damage`=10, `heal`=0 -> `start` one cycle after tick, `hp`=90 two cycles after `isComplete`.
- Heal saturation and net: `hp`=98, `heal`=1 (HEAL_AMOUNT 5) -> `hp`=100. `hp`=50, `damage`=20 with `heal`=1 -> `hp`=35.
- Death and restart: `hp`=10, `damage`=30 -> `hp`=0, `isDead`=1. Further `frameTick`s produce no `start`. `restart` -> `hp`=100, `isDead`=0.
- Timeout: `frameTick`, scanner silent -> `timeoutErr`=1 after 15 WAIT cycles, `hp` unchanged, next `frameTick` issues `start` again.
- Invulnerability (with `HP_INVULN_EN`): hit of 10 -> `hp`=90, `invuln`=1. A second hit of 10 within 30 frames leaves `hp`=90. After the 30th `frameTick` `invuln`=0, and the next hit gives `hp`=80. Without the macro both hits apply, giving `hp`=80 then 70.
- Reset mid-scan: assert `reset` in WAIT, then pulse `isComplete` with `damage`=50 -> `hp`=100 and state IDLE with no pending update.
